// File: rtl/serial_32_8_pkg.sv
// serial_32_8_pkg: shared state encoding and lane geometry for the 32-to-8 serializer.
package serial_32_8_pkg;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    localparam int BYTE_LANES = 4;
    localparam int LANE_W = 8;
endpackage

// File: rtl/serial_32_8_sel_byte.sv
// sel_byte_32_8: 4:1 byte mux picking one lane of a 32-bit word.
//   word     - 32-bit source word
//   lane     - lane number, 0 selects [7:0], 3 selects [31:24]
//   lane_byte- selected byte
module sel_byte_32_8
    import serial_32_8_pkg::*;
(
    input  logic [BYTE_LANES*LANE_W-1:0] word,
    input  logic [1:0]                   lane,
    output logic [LANE_W-1:0]            lane_byte
);
    always_comb begin
        lane_byte = lane == 2'd0 ? word[LANE_W-1:0] :
                    lane == 2'd1 ? word[2*LANE_W-1:LANE_W] :
                    lane == 2'd2 ? word[3*LANE_W-1:2*LANE_W] :
                                   word[4*LANE_W-1:3*LANE_W];
    end
endmodule

// File: rtl/serial_32_8.sv
// serial_32_8: splits 32-bit words into four bytes with valid/ready on both sides.
//   clk, reset_L           - clock and asynchronous active-low reset
//   data_in/valid_in/ready_in   - upstream word handshake
//   data_out/valid_out/ready_out- downstream byte handshake
//   byte_idx               - send-order position (0..3) of the byte on data_out
//   word_done              - high in the cycle the last byte of a word is accepted
//   MSB_FIRST              - 0 sends [7:0] first, 1 sends [31:24] first
module serial_32_8
    import serial_32_8_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [1:0]  byte_idx,
    output logic        word_done
);
    state_t      state, state_nxt;
    logic [31:0] hold, hold_nxt;
    logic [1:0]  idx_nxt, lane;
    logic        word_acc, byte_acc;

    assign lane = (MSB_FIRST != 0) ? 2'd3 - byte_idx : byte_idx;

    sel_byte_32_8 u_sel (
        .word      (hold),
        .lane      (lane),
        .lane_byte (data_out)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            hold     <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            byte_idx <= idx_nxt;
        end
    end

    // ready_in combinationally follows ready_out on the last byte so a new word
    // can be loaded on the same edge, giving gap-free back-to-back words.
    always_comb begin
        valid_out = state == SEND;
        ready_in  = state == IDLE || (byte_idx == 2'd3 && ready_out);
        word_acc  = valid_in && ready_in;
        byte_acc  = valid_out && ready_out;
        word_done = byte_acc && byte_idx == 2'd3;
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = byte_idx;
        if (word_acc) begin
            state_nxt = SEND;
            hold_nxt  = data_in;
            idx_nxt   = 2'd0;
        end else if (byte_acc) begin
            idx_nxt   = byte_idx + 2'd1;
            state_nxt = byte_idx == 2'd3 ? IDLE : SEND;
        end
    end
endmodule
